// File: rtl/io_debounce.sv
// io_debounce: synchronizes 8 switch and 5 button pins, then debounces each bit
// independently. A free-running prescaler produces a sample tick; a bit's
// debounced level changes only after STABLE_CNT consecutive ticks disagree with it.
// deb_bypass forwards the synchronized levels directly to the outputs.
// Optional macro IO_DEB_SYNC3_EN: 3-flop synchronizer instead of 2 (adds 1 cycle).
module io_debounce #(
  parameter int unsigned PRESCALE   = 1000,  // 1..65535 clk cycles per tick
  parameter int unsigned STABLE_CNT = 4      // 1..255 ticks to commit a change
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic [7:0] switch_raw,
  input  logic [4:0] button_raw,
  input  logic       deb_bypass,
  output logic [7:0] switch,
  output logic [4:0] button,
  output logic       tick_o
);

  localparam int N_IN = 13;  // bits [7:0] switches, [12:8] buttons

`ifdef IO_DEB_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
  localparam logic [7:0]  CNT_LAST = 8'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0][N_IN-1:0] sync_q;
  logic [N_IN-1:0]                  synced;
  logic [15:0]                      pre_cnt;
  logic [15:0]                      pre_cnt_nxt;
  logic [N_IN-1:0][7:0]             cnt_q;
  logic [N_IN-1:0]                  stable_q;

  // Multi-flop synchronizer: raw pins enter stage 0, the last stage is used.
  // NOTE: every flop here uses non-blocking assignment so all stages shift
  // together on the same edge instead of racing through in one cycle.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {button_raw, switch_raw}};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Next prescaler count: 0..PRESCALE-1, then wrap.
  // NOTE: the variable gets a value on every path so no latch is inferred.
  always_comb begin
    pre_cnt_nxt = pre_cnt + 16'd1;
    if (pre_cnt == PRE_LAST) begin
      pre_cnt_nxt = '0;
    end
  end

  // Prescaler and tick register: tick_o is high exactly while pre_cnt == PRESCALE-1,
  // so the debounce logic acts on the edge that ends that cycle.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      pre_cnt <= '0;
      tick_o  <= 1'b0;
    end else begin
      pre_cnt <= pre_cnt_nxt;
      tick_o  <= (pre_cnt_nxt == PRE_LAST);
    end
  end

  // Per-bit qualification counters and debounced levels; bypass forces follow mode.
  // NOTE: the counter array is plain flops, not RAM, so it is cleared by reset;
  // a partial qualification must never survive a reset.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_q    <= '0;
      stable_q <= '0;
    end else if (deb_bypass) begin
      cnt_q    <= '0;
      stable_q <= synced;
    end else if (tick_o) begin
      for (int i = 0; i < N_IN; i++) begin
        if (synced[i] != stable_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            stable_q[i] <= ~stable_q[i];
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 8'd1;
          end
        end else begin
          // Level matches again: a glitch restarts qualification.
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign {button, switch} = stable_q;

endmodule

// File: tb/tb_io_debounce.sv
// Testbench for io_debounce. Two instances: A (PRESCALE=4, STABLE_CNT=3) and
// B (PRESCALE=1, STABLE_CNT=1). Expected output levels are pushed into a
// scoreboard tagged with the clock edge where they must hold, and popped and
// compared on the falling edge after that rising edge.
module tb_io_debounce;

  localparam int P_A = 4;
  localparam int S_A = 3;
  localparam int P_B = 1;
  localparam int S_B = 1;

`ifdef IO_DEB_SYNC3_EN
  localparam int SYNC_LAT = 3;
`else
  localparam int SYNC_LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       res_n;
  logic [7:0] switch_raw_a, switch_raw_b;
  logic [4:0] button_raw_a, button_raw_b;
  logic       deb_bypass_a, deb_bypass_b;
  logic [7:0] switch_a, switch_b;
  logic [4:0] button_a, button_b;
  logic       tick_a, tick_b;

  int cyc;
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    int          at;
    bit          dut;   // 0 = instance A, 1 = instance B
    logic [12:0] exp;   // {button, switch}
  } sb_item_t;

  sb_item_t sb_q[$];

  io_debounce #(.PRESCALE(P_A), .STABLE_CNT(S_A)) u_dut_a (
    .clk       (clk),
    .res_n     (res_n),
    .switch_raw(switch_raw_a),
    .button_raw(button_raw_a),
    .deb_bypass(deb_bypass_a),
    .switch    (switch_a),
    .button    (button_a),
    .tick_o    (tick_a)
  );

  io_debounce #(.PRESCALE(P_B), .STABLE_CNT(S_B)) u_dut_b (
    .clk       (clk),
    .res_n     (res_n),
    .switch_raw(switch_raw_b),
    .button_raw(button_raw_b),
    .deb_bypass(deb_bypass_b),
    .switch    (switch_b),
    .button    (button_b),
    .tick_o    (tick_b)
  );

  always #5 clk = ~clk;

  // Rising edges seen since reset was released.
  always @(posedge clk or negedge res_n) begin
    if (!res_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input bit dut, input string tag, input int at, input logic [12:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.at  = at;
    it.dut = dut;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic push_span(input bit dut, input string tag, input int from, input int to,
                           input logic [12:0] exp);
    for (int e = from; e <= to; e++) push(dut, tag, e, exp);
  endtask

  // Edge on which a change seen at raw pins after edge k commits, given n ticks
  // of qualification and a tick on every edge that is a multiple of p.
  function automatic int commit_edge(input int k, input int n, input int p);
    int t;
    t = k + SYNC_LAT + 1;
    while (t % p != 0) t++;
    return t + (n - 1) * p;
  endfunction

  // Advance one cycle and compare every scoreboard entry now due.
  task automatic cycle();
    sb_item_t it;
    logic [12:0] obs;
    @(negedge clk);
    while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
      it  = sb_q.pop_front();
      obs = it.dut ? {button_b, switch_b} : {button_a, switch_a};
      check(it.tag, 32'(obs), 32'(it.exp));
    end
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    if (sb_q.size() != 0) begin
      check("sb_drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    int k0, k1, c, t;
    logic [12:0] exp_a;

    res_n        = 1'b0;
    switch_raw_a = '0;
    button_raw_a = '0;
    deb_bypass_a = 1'b0;
    switch_raw_b = '0;
    button_raw_b = '0;
    deb_bypass_b = 1'b0;
    exp_a        = '0;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    check("rst_a", {19'd0, button_a, switch_a, tick_a}, 32'd0);
    check("rst_b", {19'd0, button_b, switch_b, tick_b}, 32'd0);
    res_n = 1'b1;

    // Clean rising edge on switch[0]: commits on the 3rd tick, within 14 cycles.
    k0 = cyc;
    switch_raw_a = 8'h01;
    c = commit_edge(k0, S_A, P_A);
    check("sw0_latency_bound", 32'(c - k0 <= 2 + SYNC_LAT - 2 + S_A * P_A), 32'd1);
    push_span(0, "sw0_hold", k0 + 1, c - 1, exp_a);
    exp_a[0] = 1'b1;
    push(0, "sw0_commit", c, exp_a);
    run_until_empty(40);

    // 5-cycle pulse on button[2] is filtered out entirely.
    k0 = cyc;
    button_raw_a[2] = 1'b1;
    push_span(0, "btn2_pulse", k0 + 1, k0 + 20, exp_a);
    repeat (5) cycle();
    button_raw_a[2] = 1'b0;
    run_until_empty(40);

    // button[1]: two high ticks, one tick samples low, then high again;
    // commit only after three further consecutive high ticks.
    k0 = cyc;
    button_raw_a[1] = 1'b1;
    t = commit_edge(k0, 1, P_A);           // first tick seeing the high level
    c = t + 5 * P_A;                       // ticks t, t+4 high; t+8 low; t+12..t+20 high
    push_span(0, "btn1_requal_hold", k0 + 1, c - 1, exp_a);
    exp_a[9] = 1'b1;
    push(0, "btn1_requal_commit", c, exp_a);
    while (cyc < t + 2 * P_A - (SYNC_LAT + 1)) cycle();
    button_raw_a[1] = 1'b0;
    cycle();
    button_raw_a[1] = 1'b1;
    run_until_empty(60);

    // Bypass: synced value reaches the outputs SYNC_LAT+1 cycles later.
    k0 = cyc;
    deb_bypass_a = 1'b1;
    switch_raw_a = 8'hA5;
    push_span(0, "byp_before", k0 + 1, k0 + SYNC_LAT, exp_a);
    exp_a[7:0] = 8'hA5;
    push(0, "byp_follow", k0 + SYNC_LAT + 1, exp_a);
    run_until_empty(20);
    repeat (2) cycle();

    // Leave bypass with raw=00: outputs hold A5 until full qualification.
    k1 = cyc;
    deb_bypass_a = 1'b0;
    switch_raw_a = 8'h00;
    c = commit_edge(k1, S_A, P_A);
    push_span(0, "byp_exit_hold", k1 + 1, c - 1, exp_a);
    exp_a[7:0] = 8'h00;
    push(0, "byp_exit_commit", c, exp_a);
    run_until_empty(40);

    // Reset mid-qualification with all switches high.
    switch_raw_a = 8'hFF;
    repeat (6) cycle();
    #2 res_n = 1'b0;
    #1;
    check("midrst_a", {19'd0, button_a, switch_a, tick_a}, 32'd0);
    check("midrst_b", {19'd0, button_b, switch_b, tick_b}, 32'd0);
    @(negedge clk);
    res_n = 1'b1;
    c = commit_edge(0, S_A, P_A);
    push_span(0, "post_rst_hold", 1, c - 1, 13'h0);
    exp_a = {5'h02, 8'hFF};                // button[1] is still held high too
    push(0, "post_rst_commit", c, exp_a);
    for (int i = 0; i < c; i++) begin
      cycle();
      check("tick_a_phase", 32'(tick_a), 32'(cyc % P_A == P_A - 1));
      check("tick_b_every", 32'(tick_b), 32'd1);
    end
    run_until_empty(10);

    // Instance B: every cycle is a tick, single-tick qualification.
    k0 = cyc;
    button_raw_b = 5'h1F;
    c = commit_edge(k0, S_B, P_B);
    push_span(1, "b_hold", k0 + 1, c - 1, 13'h0);
    push(1, "b_commit", c, {5'h1F, 8'h00});
    run_until_empty(20);
    check("b_commit_delay", 32'(c - k0), 32'(SYNC_LAT + 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
